prbs_lfsr_gen: RTL and testbench
================================

Name: prbs_lfsr_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random bit sequence (PRBS) generator. It is the width- and polynomial-generic successor to the fixed 7-bit LFSR.
Adds the following over the fixed version:
- synchronous reset and enable
- runtime seed load
- free-run or debounced single-step advance
- sequence-period measurement
- all-zero lockup detection
Sits between board-level key/switch inputs and display or BER-test logic.

Parameters:
WIDTH, 7, LFSR length in bits; legal range 3..32.
TAPS, 7'b1100000, feedback tap mask, WIDTH bits; bit i set means state[i] feeds the XOR. Default implements x^7+x^6+1.
SEED, 1, reset and initial seed value, WIDTH bits.
CNT_W, 16, width of the period counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  global advance enable.
mode  input  1  0 = free-run (advance every cycle), 1 = single-step.
step  input  1  step request; level input, rising edge detected internally.
load  input  1  load seed_in into the LFSR and the seed register.
seed_in  input  WIDTH  seed value used by load.
prbs  output  WIDTH  current LFSR state.
bit_out  output  1  serial PRBS bit, equal to the feedback bit of the last advance.
period_done  output  1  one-cycle pulse when the state returns to the stored seed.
period_len  output  CNT_W  number of advances in the last completed period.
lockup  output  1  state is all-zero, so the LFSR is stalled.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - prbs = SEED; seed register = SEED
  - bit_out = 0; period_done = 0; period_len = 0
  - step-history flop = 0; internal counter = 0
  - lockup = (SEED == 0)
- Feedback: fb = XOR-reduce(prbs & TAPS). Next state = {prbs[WIDTH-2:0], fb}.
- Advance condition: adv = en & !lockup & (mode==0 | step_rise), where step_rise = step & !step_q. Every prbs/bit_out update is registered, giving 1-cycle latency.
- Priority: rst > load > adv > hold.
- load:
  - prbs <= seed_in; seed register <= seed_in
  - counter <= 0; period_done <= 0; bit_out <= 0
  - lockup <= (seed_in == 0)
  - load ignores en.
- On adv:
  - prbs <= next; bit_out <= fb; counter <= counter+1.
  - If next == seed register: period_done <= 1, period_len <= counter+1, counter <= 0.
- period_done is high for exactly one cycle per period, and low on all other cycles.
- Counter saturation: the counter saturates at all-ones; period_len then reports all-ones when the period completes.
- step_q samples step every cycle regardless of en. A step held high yields exactly one advance.
- Mode switching mid-run takes effect on the next cycle with no state loss.
- Lockup is reachable only by loading zero. While locked, prbs holds at 0 and no period_done occurs. Only a non-zero load or rst clears lockup.
- Simultaneous load and step_rise: the load wins and the step is consumed (not deferred).

Optional Feature:
Macro PRBS_HEX_EN.
- Defined: two extra outputs hex0[6:0] and hex1[6:0] (active-low 7-segment).
  - hex0 shows prbs[3:0]; hex1 shows prbs[7:4], zero-extended when WIDTH < 8.
  - Both are registered one cycle after prbs, so the digits lag prbs by 1 cycle. Both reset to the pattern for 0.
- Undefined: the ports and decode logic are absent; no other behaviour changes.

Decomposition:
- Shared package/header prbs_pkg holds primitive tap constants: TAPS_PRBS7 = 7'h60, TAPS_PRBS9 = 9'h110, TAPS_PRBS15 = 15'h6000, TAPS_PRBS23 = 23'h420000, TAPS_PRBS31 = 31'h48000000.
- The same package holds the default seed constant.
- One sub-module is natural: the existing hex_to_7seg, instantiated twice under PRBS_HEX_EN.
- The core LFSR stays inline.

Test Plan:
- Reset, defaults: rst=1 for 2 cycles -> prbs=7'h01, period_len=0, period_done=0, lockup=0.
- Free-run: mode=0, en=1 -> prbs sequence is 02,04,08,10,20,41,03 after 1..7 cycles; bit_out=1 on cycle 6.
- Period measurement: free-run 300 cycles -> period_done pulses on cycles 127 and 254, exactly one cycle wide; period_len=127.
- Single-step: mode=1, step held high 10 cycles then low -> exactly one advance, prbs 01->02. Three clean pulses -> prbs=08.
- Lockup: load=1 with seed_in=0 -> prbs=0, lockup=1, no advance over 50 cycles. Then load seed_in=7'h55 -> lockup=0 and the advance resumes from 55.
- Priority: load and step_rise in the same cycle with seed_in=7'h10 -> prbs=10, counter=0. Apply rst mid-run -> prbs=01 on the next edge.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared constants for the PRBS generator: primitive tap masks and the default seed.
package prbs_pkg;

  localparam logic [6:0]  TAPS_PRBS7  = 7'h60;
  localparam logic [8:0]  TAPS_PRBS9  = 9'h110;
  localparam logic [14:0] TAPS_PRBS15 = 15'h6000;
  localparam logic [22:0] TAPS_PRBS23 = 23'h420000;
  localparam logic [30:0] TAPS_PRBS31 = 31'h48000000;

  localparam int unsigned DEFAULT_SEED = 1;

  // Fallback for unlisted widths is x^w + x^(w-1) + 1, which is not always maximal-length.
  function automatic logic [31:0] taps_for_width(input int unsigned w);
    case (w)
      7:       return 32'(TAPS_PRBS7);
      9:       return 32'(TAPS_PRBS9);
      15:      return 32'(TAPS_PRBS15);
      23:      return 32'(TAPS_PRBS23);
      31:      return 32'(TAPS_PRBS31);
      default: return 32'd3 << (w - 2);
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr_gen_hex_to_7seg.sv
// Hex digit to active-low 7-segment decoder; seg_o bit 0 is segment a, bit 6 is segment g.
module hex_to_7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/prbs_lfsr_gen.sv
// Fibonacci LFSR PRBS generator with seed load, single-step, period measurement and lockup flag.
// Optional PRBS_HEX_EN adds registered 7-segment outputs hex0/hex1 for the low byte of prbs.
module prbs_lfsr_gen
  import prbs_pkg::*;
#(
  parameter int unsigned       WIDTH = 7,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(taps_for_width(WIDTH)),
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(DEFAULT_SEED),
  parameter int unsigned       CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] prbs,
  output logic             bit_out,
  output logic             period_done,
  output logic [CNT_W-1:0] period_len,
  output logic             lockup
`ifdef PRBS_HEX_EN
  ,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1
`endif
);

  logic [WIDTH-1:0] prbs_q, prbs_d, seed_q, seed_d, next_state;
  logic [CNT_W-1:0] cnt_q, cnt_d, plen_q, plen_d, cnt_inc;
  logic             bit_q, bit_d, done_q, done_d, lock_q, lock_d, step_q;
  logic             fb, step_rise, adv;

  always_comb begin
    fb         = ^(prbs_q & TAPS);
    next_state = {prbs_q[WIDTH-2:0], fb};
    step_rise  = step & ~step_q;
    adv        = en & ~lock_q & (~mode | step_rise);
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    prbs_d = prbs_q;
    seed_d = seed_q;
    bit_d  = bit_q;
    done_d = 1'b0;
    plen_d = plen_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;

    // A load consumes any coincident step edge: step_q still tracks step, so it is not replayed.
    if (load) begin
      prbs_d = seed_in;
      seed_d = seed_in;
      bit_d  = 1'b0;
      cnt_d  = '0;
      lock_d = (seed_in == '0);
    end else if (adv) begin
      prbs_d = next_state;
      bit_d  = fb;
      cnt_d  = cnt_inc;
      if (next_state == seed_q) begin
        done_d = 1'b1;
        plen_d = cnt_inc;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prbs_q <= SEED;
      seed_q <= SEED;
      bit_q  <= 1'b0;
      done_q <= 1'b0;
      plen_q <= '0;
      cnt_q  <= '0;
      lock_q <= (SEED == '0);
      step_q <= 1'b0;
    end else begin
      prbs_q <= prbs_d;
      seed_q <= seed_d;
      bit_q  <= bit_d;
      done_q <= done_d;
      plen_q <= plen_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      step_q <= step;
    end
  end

  assign prbs        = prbs_q;
  assign bit_out     = bit_q;
  assign period_done = done_q;
  assign period_len  = plen_q;
  assign lockup      = lock_q;

`ifdef PRBS_HEX_EN
  logic [7:0] low8;
  logic [6:0] seg0, seg1, hex0_q, hex1_q;

  generate
    if (WIDTH >= 8) begin : g_wide
      assign low8 = prbs_q[7:0];
    end else begin : g_narrow
      assign low8 = {{(8 - WIDTH){1'b0}}, prbs_q};
    end
  endgenerate

  hex_to_7seg u_hex0 (.hex_i(low8[3:0]), .seg_o(seg0));
  hex_to_7seg u_hex1 (.hex_i(low8[7:4]), .seg_o(seg1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hex0_q <= 7'h40;
      hex1_q <= 7'h40;
    end else begin
      hex0_q <= seg0;
      hex1_q <= seg1;
    end
  end

  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
`endif

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Scoreboard bench for prbs_lfsr_gen: directed test-plan checks plus randomized traffic vs a reference model.
module tb_prbs_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst, en, mode, step, load;
  logic [6:0] seed_in;
  logic [6:0] prbs;
  logic       bit_out, period_done, lockup;
  logic [15:0] period_len;
`ifdef PRBS_HEX_EN
  logic [6:0] hex0, hex1;
`endif

  prbs_lfsr_gen dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step), .load(load),
    .seed_in(seed_in), .prbs(prbs), .bit_out(bit_out), .period_done(period_done),
    .period_len(period_len), .lockup(lockup)
`ifdef PRBS_HEX_EN
    , .hex0(hex0), .hex1(hex1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  prbs;
    logic        bit_o;
    logic        done;
    logic [15:0] plen;
    logic        lock;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  // Reference model state: the generator is a shift-left of the state with parity of tapped bits.
  localparam int unsigned TAP_MASK = 'h60;
  int unsigned m_prbs, m_seed, m_cnt, m_plen;
  bit          m_bit, m_done, m_lock, m_last_step;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected post-edge outputs.
  task automatic cyc(input bit r, input bit e, input bit m, input bit s, input bit l,
                     input logic [6:0] sd);
    int unsigned nxt, fb;
    bit rise;
    exp_t ex;
    @(negedge clk);
    rst = r; en = e; mode = m; step = s; load = l; seed_in = sd;
    rise = s && !m_last_step;
    m_done = 1'b0;
    if (r) begin
      m_prbs = 1; m_seed = 1; m_bit = 0; m_plen = 0; m_cnt = 0; m_lock = 0;
      m_last_step = 0;
    end else begin
      if (l) begin
        m_prbs = sd; m_seed = sd; m_cnt = 0; m_bit = 0; m_lock = (sd == 0);
      end else if (e && !m_lock && (!m || rise)) begin
        fb  = $countones(m_prbs & TAP_MASK) % 2;
        nxt = ((m_prbs * 2) + fb) % 128;
        m_bit = fb[0];
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (nxt == m_seed) begin
          m_done = 1'b1;
          m_plen = m_cnt;
          m_cnt  = 0;
        end
        m_prbs = nxt;
      end
      m_last_step = s;
    end
    ex.prbs = m_prbs[6:0]; ex.bit_o = m_bit; ex.done = m_done;
    ex.plen = m_plen[15:0]; ex.lock = m_lock;
    q.push_back(ex);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clock edge with an outstanding expectation, compare the DUT against it.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        txn++;
        total++;
        if (prbs !== ex.prbs || bit_out !== ex.bit_o || period_done !== ex.done ||
            period_len !== ex.plen || lockup !== ex.lock) begin
          bad++;
          $display("FAIL txn%0d: got prbs=%h bit=%b done=%b len=%0d lock=%b expected prbs=%h bit=%b done=%b len=%0d lock=%b",
                   txn, prbs, bit_out, period_done, period_len, lockup,
                   ex.prbs, ex.bit_o, ex.done, ex.plen, ex.lock);
        end else begin
          $display("txn%0d prbs=%h bit=%b done=%b len=%0d lock=%b",
                   txn, prbs, bit_out, period_done, period_len, lockup);
        end
      end
    end
  end

  initial begin
    logic [6:0] fr_tab [7];
    int pulses, first_p, second_p, waited;
    fr_tab = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
    rst = 1; en = 0; mode = 0; step = 0; load = 0; seed_in = 0;
    m_last_step = 0;

    // Reset defaults
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    settle();
    chk("rst_prbs", prbs, 'h01);
    chk("rst_len", period_len, 0);
    chk("rst_done", period_done, 0);
    chk("rst_lock", lockup, 0);

    // Free-run sequence
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      settle();
      chk("freerun_prbs", prbs, fr_tab[i]);
      if (i == 5) chk("freerun_bit6", bit_out, 1);
    end

    // Period measurement over 300 cycles
    cyc(1, 0, 0, 0, 0, 0);
    pulses = 0; first_p = 0; second_p = 0;
    for (int k = 1; k <= 300; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      settle();
      if (period_done === 1'b1) begin
        pulses++;
        if (pulses == 1) first_p = k;
        if (pulses == 2) second_p = k;
      end
    end
    chk("period_pulses", pulses, 2);
    chk("period_first", first_p, 127);
    chk("period_second", second_p, 254);
    chk("period_len", period_len, 127);

    // Single-step: held step gives one advance; three clean pulses from reset reach 08
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    settle();
    chk("step_held", prbs, 'h02);
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
    end
    settle();
    chk("step_pulses", prbs, 'h08);

    // Lockup via zero load, then recovery
    cyc(0, 1, 0, 0, 1, 7'h00);
    settle();
    chk("lock_prbs", prbs, 0);
    chk("lock_flag", lockup, 1);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      settle();
      if (period_done === 1'b1) pulses++;
    end
    chk("lock_hold", prbs, 0);
    chk("lock_nodone", pulses, 0);
    cyc(0, 1, 0, 0, 1, 7'h55);
    settle();
    chk("unlock_flag", lockup, 0);
    chk("unlock_prbs", prbs, 'h55);
    cyc(0, 1, 0, 0, 0, 0);
    settle();
    chk("unlock_adv", prbs, 'h2B);

    // Load beats a coincident step edge, and the step is not replayed
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 7'h10);
    settle();
    chk("prio_load", prbs, 'h10);
    cyc(0, 1, 1, 1, 0, 0);
    settle();
    chk("prio_consumed", prbs, 'h10);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    settle();
    chk("midrun_rst", prbs, 'h01);

    // Randomized traffic, including mode switching, zero loads and occasional resets
    for (int i = 0; i < 2000; i++) begin
      logic [6:0] sd;
      bit ld;
      ld = ($urandom_range(0, 31) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      cyc(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0), 1'($urandom), ld, sd);
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
